sram_access_controller: RTL and testbench
=========================================

Name: sram_access_controller

Overview:
- Sequences every data-memory access issued by the MEM stage onto an external single-port SRAM with a fixed multi-cycle access time.
- Drives the SRAM control, address and write-data pins and returns read data.
- Holds `ready` low while an access is in flight. The pipeline control gates all stage registers (IF through MEM/WB) and the forwarding selects with `ready`, so the pipeline freezes until the access completes.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 18, SRAM word-address width.
- WAIT_CYCLES, 5, SRAM access time in clock cycles; legal range 1..15.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_r_en  input  1  MEM-stage load request.
- mem_w_en  input  1  MEM-stage store request.
- addr  input  32  byte address from ALU result.
- wdata  input  DATA_W  store data (forwarded Val_Rm).
- ready  output  1  access complete / no access pending; pipeline advances only when 1.
- rdata  output  DATA_W  registered load data.
- sram_addr  output  ADDR_W  SRAM word address.
- sram_wdata  output  DATA_W  SRAM write data.
- sram_rdata  input  DATA_W  SRAM read data.
- sram_we_n  output  1  SRAM write enable, active low.
- sram_oe_n  output  1  SRAM output enable, active low.

Behaviour:
- Reset (async, rst_n=0): the following hold immediately and during reset.
  - state=IDLE, counter=0.
  - rdata=0, sram_addr=0, sram_wdata=0.
  - sram_we_n=1, sram_oe_n=1.
  - ready follows the IDLE rule with req treated as 0, so ready=1.
- req = mem_r_en | mem_w_en. If both are asserted, the access is a write; the read is dropped.
- Address translation: word = (addr - BASE_ADDR) >> 2, truncated to ADDR_W. addr[1:0] is ignored. Addresses below BASE_ADDR wrap modulo 2^ADDR_W; no error is flagged.
- States:
  - IDLE: when req=1, latch the word address, wdata and the op (write/read) into internal registers. Next state is ACCESS with counter=0.
  - ACCESS: on each cycle, counter increments.
    - sram_addr and sram_wdata drive the latched values.
    - For a write, sram_we_n=0 and sram_oe_n=1.
    - For a read, sram_we_n=1 and sram_oe_n=0.
    - When counter==WAIT_CYCLES-1: for a read, sample sram_rdata into rdata. Next state is DONE.
  - DONE: sram_we_n=1, sram_oe_n=1, ready=1 for exactly one cycle. Requests in DONE are ignored, because they are the same instruction still held. Next state is IDLE unconditionally.
- ready is combinational: (state==IDLE && !req) || state==DONE. It drops low in the same cycle a request first appears, so no stage register captures that edge.
- Latency: a request first seen at cycle 0 gives ready=0 for cycles 0..WAIT_CYCLES and ready=1 at cycle WAIT_CYCLES+1. The pipeline freezes for WAIT_CYCLES+1 cycles.
- Back-to-back memory instructions: the second request is seen in the IDLE cycle after DONE, with ready=0 in that same cycle. There is no dead cycle beyond the one IDLE cycle.
- rdata holds its value until the next read completes; writes never modify rdata.
- Request inputs changing during ACCESS are ignored; the latched values are used.
- Reset asserted mid-ACCESS aborts the access: sram_we_n returns to 1 immediately, and rdata is cleared.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> ready=1, sram_we_n=1, sram_oe_n=1 and rdata=0 with no clock edge.
- Read, WAIT_CYCLES=5: mem_r_en=1, addr=1032, sram_rdata=0xDEADBEEF -> sram_addr=2, sram_oe_n=0 for 5 cycles, ready=0 cycles 0..5, ready=1 cycle 6, rdata=0xDEADBEEF from cycle 6.
- Write: mem_w_en=1, addr=1028, wdata=0x12345678 -> sram_addr=1, sram_wdata=0x12345678, sram_we_n=0 for exactly 5 cycles, rdata unchanged, ready=1 at cycle 6.
- Simultaneous r/w: mem_r_en=mem_w_en=1 -> write cycle performed (sram_we_n=0), rdata unchanged.
- Back-to-back: a write then a read, each held until ready -> second access starts in the IDLE cycle after DONE, with ready=0 in that cycle; total 14 cycles from first request to second DONE.
- Reset mid-write: rst_n=0 at ACCESS counter=2 -> sram_we_n=1 immediately; after release, state is IDLE and ready=1 with no request.

Source files
------------

// File: rtl/sram_access_controller.sv
// Sequences MEM-stage loads/stores onto a single-port SRAM with a fixed access time.
// ready stays low from the first request cycle until the one-cycle DONE state.
module sram_access_controller #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  counter, counter_next;
  logic        lat_write;
  logic        req;
  logic        last;
  logic [31:0] offset;
  logic [ADDR_W-1:0] word;

  assign req    = mem_r_en | mem_w_en;
  // Addresses below BASE_ADDR wrap silently through the subtraction.
  assign offset = addr - 32'(BASE_ADDR);
  assign word   = offset[ADDR_W+1:2];
  assign last   = (counter == 4'(WAIT_CYCLES - 1));

  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      IDLE: begin
        if (req) begin
          state_next   = ACCESS;
          counter_next = 4'd0;
        end
      end
      ACCESS: begin
        if (last) begin
          state_next   = DONE;
          counter_next = 4'd0;
        end else begin
          counter_next = counter + 4'd1;
        end
      end
      DONE: begin
        // A request seen here is the same instruction still held; drop it.
        state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        counter_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= 4'd0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // sram_addr/sram_wdata are the latched request fields themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
      lat_write  <= 1'b0;
      rdata      <= '0;
    end else begin
      if (state == IDLE && req) begin
        sram_addr  <= word;
        sram_wdata <= wdata;
        lat_write  <= mem_w_en;
      end
      if (state == ACCESS && last && !lat_write) begin
        rdata <= sram_rdata;
      end
    end
  end

  assign ready     = (state == IDLE && !req) || (state == DONE);
  assign sram_we_n = !(state == ACCESS && lat_write);
  assign sram_oe_n = !(state == ACCESS && !lat_write);

endmodule

// File: tb/tb_sram_access_controller.sv
// Self-checking bench for sram_access_controller: directed scenarios plus a
// randomized transaction stream checked against a per-transaction timeline model.
module tb_sram_access_controller;
  localparam int DW   = 32;
  localparam int AW   = 18;
  localparam int WC   = 5;
  localparam int BASE = 1024;

  logic          clk;
  logic          rst_n;
  logic          mem_r_en;
  logic          mem_w_en;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          sram_we_n;
  logic          sram_oe_n;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_rdata = '0;

  sram_access_controller #(
    .DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'(BASE);
    return AW'((d / 4) % (32'd1 << AW));
  endfunction

  // One access: cycle 0 is the IDLE cycle where the request first appears,
  // cycles 1..WC are the SRAM access, cycle WC+1 is the DONE cycle.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] srd,
                           output time t0, output time tdone);
    logic          is_write;
    logic [AW-1:0] exp_word;
    logic [DW-1:0] exp_wd;
    logic          exp_ready, exp_we, exp_oe, in_access;
    is_write = w;
    exp_word = word_of(a);
    exp_wd   = d;
    t0 = 0;
    tdone = 0;
    if (!is_write) exp_q.push_back(srd);
    mem_r_en = r; mem_w_en = w; addr = a; wdata = d; sram_rdata = srd;
    for (int k = 0; k <= WC + 1; k++) begin
      @(negedge clk);
      if (k == 0) t0 = $time;
      if (k == WC + 1) tdone = $time;
      in_access = (k >= 1 && k <= WC);
      exp_ready = (k == WC + 1);
      exp_we    = !(is_write && in_access);
      exp_oe    = !(!is_write && in_access);
      if (k == WC + 1 && !is_write) model_rdata = exp_q.pop_front();
      n_cmp++;
      if (ready !== exp_ready) begin
        n_fail++;
        $display("FAIL ready k=%0d: got %b expected %b", k, ready, exp_ready);
      end
      n_cmp++;
      if (sram_we_n !== exp_we) begin
        n_fail++;
        $display("FAIL sram_we_n k=%0d: got %b expected %b", k, sram_we_n, exp_we);
      end
      n_cmp++;
      if (sram_oe_n !== exp_oe) begin
        n_fail++;
        $display("FAIL sram_oe_n k=%0d: got %b expected %b", k, sram_oe_n, exp_oe);
      end
      n_cmp++;
      if (rdata !== model_rdata) begin
        n_fail++;
        $display("FAIL rdata k=%0d: got %h expected %h", k, rdata, model_rdata);
      end
      if (in_access) begin
        n_cmp++;
        if (sram_addr !== exp_word) begin
          n_fail++;
          $display("FAIL sram_addr k=%0d: got %h expected %h", k, sram_addr, exp_word);
        end
        n_cmp++;
        if (sram_wdata !== exp_wd) begin
          n_fail++;
          $display("FAIL sram_wdata k=%0d: got %h expected %h", k, sram_wdata, exp_wd);
        end
      end
      @(posedge clk);
      #1;
      // Address/data wiggle mid-access must not leak into the SRAM pins.
      if (k < WC) begin
        addr  = $urandom;
        wdata = $urandom;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
        n_fail++;
        $display("FAIL idle: got ready=%b we_n=%b oe_n=%b expected 1/1/1",
                 ready, sram_we_n, sram_oe_n);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
    addr = '0; wdata = '0; sram_rdata = '0;
    #13;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b we_n=%b oe_n=%b expected 1/1/1",
               ready, sram_we_n, sram_oe_n);
    end
    n_cmp++;
    if (rdata !== '0 || sram_addr !== '0 || sram_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected 0",
               rdata, sram_addr, sram_wdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(2);
  endtask

  task automatic test_read();
    time t0, t1;
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, t0, t1);
    idle_cycles(1);
    n_cmp++;
    if (rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_hold: got %h expected %h", rdata, 32'hDEADBEEF);
    end
  endtask

  task automatic test_write();
    time t0, t1;
    do_access(1'b0, 1'b1, 32'd1028, 32'h12345678, 32'hA5A5A5A5, t0, t1);
    idle_cycles(1);
  endtask

  task automatic test_simultaneous();
    time t0, t1;
    do_access(1'b1, 1'b1, 32'd1100, 32'hCAFEF00D, 32'h0BADBEEF, t0, t1);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    time t0, t1, t2, t3;
    do_access(1'b0, 1'b1, 32'd1040, 32'h11112222, 32'h0, t0, t1);
    do_access(1'b1, 1'b0, 32'd1044, 32'h0, 32'h33334444, t2, t3);
    n_cmp++;
    if ((t3 - t0) / 10 + 1 != 14) begin
      n_fail++;
      $display("FAIL b2b_span: got %0d expected 14", (t3 - t0) / 10 + 1);
    end
    idle_cycles(1);
  endtask

  task automatic test_random();
    time t0, t1;
    logic r, w;
    logic [31:0] a;
    int op;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      r = (op != 1);
      w = (op != 0);
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'(BASE) + $urandom_range(0, 4 * ((1 << AW) - 1) + 3);
      do_access(r, w, a, $urandom, $urandom, t0, t1);
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_write();
    time t0, t1;
    do_access(1'b1, 1'b0, 32'd2048, 32'h0, 32'h5555AAAA, t0, t1);
    idle_cycles(1);
    mem_w_en = 1'b1; mem_r_en = 1'b0; addr = 32'd1036; wdata = 32'h77778888;
    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (sram_we_n !== 1'b0) begin
      n_fail++;
      $display("FAIL midwr_active: got we_n=%b expected 0", sram_we_n);
    end
    rst_n = 1'b0;
    #1;
    model_rdata = '0;
    exp_q.delete();
    n_cmp++;
    if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || rdata !== '0) begin
      n_fail++;
      $display("FAIL midwr_abort: got we_n=%b oe_n=%b rdata=%h expected 1/1/0",
               sram_we_n, sram_oe_n, rdata);
    end
    mem_w_en = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || sram_addr !== '0) begin
      n_fail++;
      $display("FAIL post_reset: got ready=%b addr=%h expected 1/0", ready, sram_addr);
    end
    @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, 32'h600DF00D, t0, t1);
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
